// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, PC/writeback
// mux selects and memory transfer sizes.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JAL    = 2'b10;
  localparam logic [1:0] PC_SEL_JALR   = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] XFER_BYTE = 2'b00;
  localparam logic [1:0] XFER_HALF = 2'b01;
  localparam logic [1:0] XFER_WORD = 2'b10;

endpackage

// File: rtl/seq_counters.sv
// Cycle, retired-instruction and memory wait counters for the sequencer.
// at_limit flags the last permitted wait cycle; the FSM qualifies it with ready.
module seq_counters #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 count_en,
  input  logic                 retire,
  input  logic                 wait_pending,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 at_limit
);

  localparam int unsigned WW = 16;

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [WW-1:0]        wait_q, wait_d;

  always_comb begin
    cycle_d   = count_en ? cycle_q + CNT_WIDTH'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
    wait_d    = wait_pending ? wait_q + WW'(1) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;
  assign at_limit    = (wait_q == WW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with sticky halt on illegal instruction or memory timeout.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run_en,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [1:0]           dmem_size,
  input  logic                 dmem_ready,
  input  logic                 dec_reg_write,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_branch,
  input  logic                 dec_jal,
  input  logic                 dec_jalr,
  input  logic                 dec_illegal,
  input  logic [1:0]           xfer_size,
  input  logic                 branch_taken,
  output logic                 ir_load,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 err,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret
);

  seq_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       retire, wait_pending, at_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_size    = XFER_BYTE;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    wait_pending = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        // Gated by reset_n so the request also reads 0 while reset is held.
        imem_req = run_en & reset_n;
        if (imem_req && imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (imem_req) begin
          wait_pending = 1'b1;
          if (at_limit) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_HALT;
          err_d   = 1'b0;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (dec_is_load || dec_is_store) begin
          state_d = ST_MEMORY;
        end else if (dec_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (dec_jal || dec_jalr || dec_reg_write) begin
          state_d = ST_WRITEBACK;
        end else begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEMORY: begin
        dmem_req  = 1'b1;
        dmem_we   = dec_is_store;
        dmem_size = xfer_size;
        if (dmem_ready) begin
          if (dec_is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else begin
          wait_pending = 1'b1;
          if (at_limit) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (dec_is_load) begin
          wb_sel = WB_SEL_MEM;
        end else if (dec_jal) begin
          wb_sel = WB_SEL_PC4;
          pc_sel = PC_SEL_JAL;
        end else if (dec_jalr) begin
          wb_sel = WB_SEL_PC4;
          pc_sel = PC_SEL_JALR;
        end
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  seq_counters #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_counters (
    .clk         (clk),
    .reset_n     (reset_n),
    .count_en    (state_q != ST_HALT),
    .retire      (retire),
    .wait_pending(wait_pending),
    .cycle_count (cycle_count),
    .instret     (instret),
    .at_limit    (at_limit)
  );

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);
  assign err    = err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction class is expanded into its
// expected per-cycle trace from the sequencing rules and compared cycle by cycle.
module tb_multicycle_sequencer;

  localparam int unsigned CW = 6;
  localparam int unsigned TO = 4;

  typedef enum int {C_ALU, C_NOP, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_ILL} cls_t;

  logic          clk = 1'b0;
  logic          reset_n, run_en, imem_ready, dmem_ready;
  logic          dec_reg_write, dec_is_load, dec_is_store, dec_branch;
  logic          dec_jal, dec_jalr, dec_illegal, branch_taken;
  logic [1:0]    xfer_size;
  logic          imem_req, dmem_req, dmem_we, ir_load, pc_we, rf_we, halted, err;
  logic [1:0]    dmem_size, pc_sel, wb_sel;
  logic [2:0]    state;
  logic [CW-1:0] cycle_count, instret;

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned m_cyc = 0, m_ret = 0;
  logic        m_err = 1'b0;

  logic [2:0]  e_st;
  logic        e_ireq, e_irl, e_dreq, e_dwe, e_pcwe, e_rfwe;
  logic [1:0]  e_dsz, e_pcsel, e_wbsel;

  multicycle_sequencer #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_ready(dmem_ready),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_branch(dec_branch), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_illegal(dec_illegal),
    .xfer_size(xfer_size), .branch_taken(branch_taken),
    .ir_load(ir_load), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .err(err), .state(state),
    .cycle_count(cycle_count), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_base(input logic [2:0] st);
    e_st = st; e_ireq = 0; e_irl = 0; e_dreq = 0; e_dwe = 0; e_pcwe = 0; e_rfwe = 0;
    e_dsz = 0; e_pcsel = 0; e_wbsel = 0;
  endtask

  // Checks one cycle at the falling edge, then advances past the next rising edge.
  task automatic cyc(input bit retire);
    @(negedge clk);
    chk("state",       32'(state),       32'(e_st));
    chk("imem_req",    32'(imem_req),    32'(e_ireq));
    chk("ir_load",     32'(ir_load),     32'(e_irl));
    chk("dmem_req",    32'(dmem_req),    32'(e_dreq));
    chk("dmem_we",     32'(dmem_we),     32'(e_dwe));
    chk("dmem_size",   32'(dmem_size),   32'(e_dsz));
    chk("pc_we",       32'(pc_we),       32'(e_pcwe));
    chk("pc_sel",      32'(pc_sel),      32'(e_pcsel));
    chk("rf_we",       32'(rf_we),       32'(e_rfwe));
    chk("wb_sel",      32'(wb_sel),      32'(e_wbsel));
    chk("halted",      32'(halted),      32'(e_st == 3'd5));
    if (e_st == 3'd5) chk("err", 32'(err), 32'(m_err));
    chk("cycle_count", 32'(cycle_count), m_cyc % (1 << CW));
    chk("instret",     32'(instret),     m_ret % (1 << CW));
    @(posedge clk); #1;
    if (e_st != 3'd5) m_cyc++;
    if (retire) m_ret++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state",    32'(state),       0);
    chk("rst_imem_req", 32'(imem_req),    0);
    chk("rst_dmem_req", 32'(dmem_req),    0);
    chk("rst_halted",   32'(halted),      0);
    chk("rst_err",      32'(err),         0);
    chk("rst_cycles",   32'(cycle_count), 0);
    chk("rst_instret",  32'(instret),     0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_cyc = 0; m_ret = 0; m_err = 1'b0;
  endtask

  task automatic go_halt(input logic e);
    m_err = e;
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      exp_base(3'd5);
      cyc(1'b0);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset();
  endtask

  task automatic idle(input int unsigned n);
    run_en = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      imem_ready = 1'($urandom_range(0, 1));
      exp_base(3'd0);
      cyc(1'b0);
    end
    imem_ready = 1'b0;
  endtask

  task automatic run_instr(input cls_t c, input int unsigned idly, input int unsigned ddly,
                           input logic tk, input logic [1:0] sz, input bit abort);
    dec_reg_write = (c == C_ALU || c == C_LOAD || c == C_JAL || c == C_JALR);
    dec_is_load   = (c == C_LOAD);
    dec_is_store  = (c == C_STORE);
    dec_branch    = (c == C_BR);
    dec_jal       = (c == C_JAL);
    dec_jalr      = (c == C_JALR);
    dec_illegal   = (c == C_ILL);
    xfer_size     = sz;
    branch_taken  = tk;
    run_en        = 1'b1;
    for (int unsigned i = 0; ; i++) begin
      if (i == TO) begin go_halt(1'b1); return; end
      imem_ready = (i == idly);
      exp_base(3'd0); e_ireq = 1; e_irl = (i == idly);
      cyc(1'b0);
      if (i == idly) break;
    end
    imem_ready = 1'b0;
    exp_base(3'd1); cyc(1'b0);
    if (c == C_ILL) begin go_halt(1'b0); return; end
    exp_base(3'd2);
    if (c == C_BR) begin
      e_pcwe = 1; e_pcsel = tk ? 2'b01 : 2'b00; cyc(1'b1); return;
    end
    if (c == C_NOP) begin
      e_pcwe = 1; cyc(1'b1); return;
    end
    cyc(1'b0);
    if (c == C_LOAD || c == C_STORE) begin
      for (int unsigned i = 0; ; i++) begin
        if (abort && i == 1) begin
          dmem_ready = 1'b0;
          @(negedge clk);
          chk("mid_dmem_req", 32'(dmem_req), 1);
          do_reset();
          return;
        end
        if (i == TO) begin go_halt(1'b1); return; end
        dmem_ready = (i == ddly);
        exp_base(3'd3); e_dreq = 1; e_dwe = (c == C_STORE); e_dsz = sz;
        e_pcwe = (c == C_STORE && i == ddly);
        cyc(c == C_STORE && i == ddly);
        if (i == ddly) break;
      end
      dmem_ready = 1'b0;
      if (c == C_STORE) return;
    end
    exp_base(3'd4); e_rfwe = 1; e_pcwe = 1;
    if (c == C_LOAD) e_wbsel = 2'b01;
    else if (c == C_JAL) begin e_wbsel = 2'b10; e_pcsel = 2'b10; end
    else if (c == C_JALR) begin e_wbsel = 2'b10; e_pcsel = 2'b11; end
    cyc(1'b1);
  endtask

  initial begin
    cls_t        c;
    int unsigned idly, ddly;
    reset_n = 1'b0; run_en = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_reg_write = 0; dec_is_load = 0; dec_is_store = 0; dec_branch = 0;
    dec_jal = 0; dec_jalr = 0; dec_illegal = 0; branch_taken = 0; xfer_size = 0;
    do_reset();

    run_instr(C_ALU,  0, 0, 1'b0, 2'b00, 0);
    run_instr(C_LOAD, 0, 3, 1'b0, 2'b10, 0);
    run_instr(C_BR,   0, 0, 1'b1, 2'b00, 0);
    run_instr(C_BR,   0, 0, 1'b0, 2'b00, 0);
    run_instr(C_JALR, 0, 0, 1'b0, 2'b00, 0);
    run_instr(C_ILL,  0, 0, 1'b0, 2'b00, 0);
    run_instr(C_STORE, 0, TO, 1'b0, 2'b01, 0);
    run_instr(C_STORE, 0, TO - 1, 1'b0, 2'b01, 0);
    run_instr(C_ALU,  TO, 0, 1'b0, 2'b00, 0);
    run_instr(C_STORE, 0, 3, 1'b0, 2'b10, 1);
    idle(3);
    run_instr(C_JAL,  1, 0, 1'b0, 2'b00, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      c    = ($urandom_range(0, 99) == 0) ? C_ILL : cls_t'($urandom_range(0, 6));
      idly = ($urandom_range(0, 49) == 0) ? TO : $urandom_range(0, 3);
      ddly = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, 3);
      run_instr(c, idly, ddly, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
